draw_sprite: RTL and testbench
==============================

# draw_sprite

Parametrised sprite overlay stage for the VGA pipeline, the generalised successor of the fixed-position player drawers. It overlays a SPRITE_W × SPRITE_H image, read from an external synchronous ROM, at a runtime-movable position with colour-key transparency, horizontal mirroring and multi-frame animation. It sits in the `vga_if` chain between background/other draw stages and the VGA output, and adds 2 cycles of latency to every timing signal.

## Interface
- SPRITE_W, default 64: sprite width in pixels; power of two, 2..256
- SPRITE_H, default 64: sprite height in pixels; power of two, 2..256
- FRAMES, default 4: animation frames stored back-to-back in ROM; power of two, 1..16
- FRAME_TICKS, default 8: video frames per animation step; ≥1
- KEY_COLOR, default 12'hF0F: ROM colour treated as transparent
- clk60MHz  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- xpos  in  11  requested sprite left edge (hcount units)
- ypos  in  11  requested sprite top edge (vcount units)
- mirror  in  1  1 = draw horizontally flipped
- visible  in  1  0 = sprite suppressed, stream passes through
- anim_en  in  1  1 = animation advances
- rgb_pixel  in  12  ROM data, valid 1 cycle after pixel_addr
- pixel_addr  out  log2(FRAMES)+log2(SPRITE_H)+log2(SPRITE_W)  ROM address {frame, row, col}
- frame_idx  out  log2(FRAMES) (min 1)  current animation frame
- in  vga_if.in  —  incoming timing + rgb
- out  vga_if.out  —  delayed timing + composited rgb

## Operation
- Frame-start event F: in.vcount==0 && in.hcount==0, sampled on a clock edge.
- On F: xpos, ypos, mirror, visible are latched into x_l, y_l, mir_l, vis_l. All drawing uses the latched values, so a position change never tears mid-frame.
- Animation on F when anim_en=1: tick counter increments; when it equals FRAME_TICKS-1 it wraps to 0 and frame_idx increments modulo FRAMES (FRAMES-1 → 0). anim_en=0 holds both counters. FRAMES=1 → frame_idx constant 0.
- Stage 0 (combinational on in.*): dx = in.hcount − x_l, dy = in.vcount − y_l in 12-bit arithmetic. hit0 = vis_l && !in.hblnk && !in.vblnk && in.hcount ≥ x_l && in.hcount < x_l+SPRITE_W && in.vcount ≥ y_l && in.vcount < y_l+SPRITE_H; comparisons are 12-bit, so a sprite extending past the screen edge clips and never wraps to column/row 0.
- col = mir_l ? SPRITE_W−1−dx : dx (low log2(SPRITE_W) bits); row = dy low bits; pixel_addr = {frame_idx, row, col}. Outside the window the address is don't-care but deterministic.
- Stage 1 registers: timing signals, in.rgb, hit0 → hit1.
- Stage 2 (out): out.rgb = (hit1 && rgb_pixel != KEY_COLOR) ? rgb_pixel : stage-1 rgb; timing signals forwarded from stage 1.
- Latched parameters and frame_idx change only on F, so the mapping of pixel_addr to the pixel reaching stage 2 is always consistent.

## Timing
- Latency in → out: exactly 2 cycles for vcount, hcount, vsync, hsync, vblnk, hblnk, rgb.
- ROM read latency assumed exactly 1 cycle; rgb_pixel is consumed in the stage-1 → stage-2 transfer.
- Latch/animation update takes effect from the cycle after F; the F pixel itself (0,0) is drawn with the new values.
- Reset (asynchronous assert, synchronous-safe deassert): all out.* = 0, x_l = y_l = 0, mir_l = vis_l = 0, tick counter = 0, frame_idx = 0, pipeline registers 0. Reset asserted mid-frame clears immediately; drawing resumes after the next F (vis_l = 0 until then).
- Simultaneous F and xpos/visible change: the value present at the F edge is the one latched.

## Test plan
- Static draw: xpos=100, ypos=50, visible=1, ROM = address-coded pattern → pixel (100,50) outputs ROM[{0,0,0}], (163,113) outputs ROM[{0,63,63}]; (99,50) and (164,50) pass in.rgb; out delayed exactly 2 cycles.
- Transparency: ROM word = 12'hF0F inside window → out.rgb equals background in.rgb; 12'hF0E → ROM colour shown.
- Mirror: mirror=1, xpos=100 → pixel (100,50) addresses col 63, (163,50) addresses col 0.
- Edge clip and mid-frame move: xpos=1000 → columns 1000..1023 drawn, columns 0..39 show background; change xpos at vcount=300 → position changes only after the next F.
- Animation: FRAMES=4, FRAME_TICKS=2, anim_en=1 → frame_idx sequence 0,0,1,1,2,2,3,3,0 over successive F; anim_en=0 holds value; visible=0 → out.rgb == in.rgb everywhere.
- Async reset: assert rst_n=0 mid-line without a clock edge → all outputs 0 immediately; after release, no sprite until the first F.

Source files
------------

// File: rtl/draw_sprite_if.sv
// VGA timing + colour bundle passed between draw stages of the video pipeline.
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
    modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_sprite.sv
// Sprite overlay stage: ROM-backed sprite at a frame-latched position with colour-key
// transparency, horizontal mirroring and frame animation; 2-cycle pass-through latency.
module draw_sprite #(
    parameter int          SPRITE_W    = 64,
    parameter int          SPRITE_H    = 64,
    parameter int          FRAMES      = 4,
    parameter int          FRAME_TICKS = 8,
    parameter logic [11:0] KEY_COLOR   = 12'hF0F,
    localparam int CW  = $clog2(SPRITE_W),
    localparam int RW  = $clog2(SPRITE_H),
    localparam int FA  = $clog2(FRAMES),
    localparam int FIW = (FA < 1) ? 1 : FA,
    localparam int AW  = FA + RW + CW,
    localparam int TW  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1
) (
    input  logic           clk60MHz,
    input  logic           rst_n,
    input  logic [10:0]    xpos,
    input  logic [10:0]    ypos,
    input  logic           mirror,
    input  logic           visible,
    input  logic           anim_en,
    input  logic [11:0]    rgb_pixel,
    output logic [AW-1:0]  pixel_addr,
    output logic [FIW-1:0] frame_idx,
    vga_if.in              in,
    vga_if.out             out
);

    logic [10:0]    x_l_q, x_l_d;
    logic [10:0]    y_l_q, y_l_d;
    logic           mir_l_q, mir_l_d;
    logic           vis_l_q, vis_l_d;
    logic [TW-1:0]  tick_q, tick_d;
    logic [FIW-1:0] frame_q, frame_d;

    logic [10:0] vcount1_q, hcount1_q;
    logic        vsync1_q, hsync1_q, vblnk1_q, hblnk1_q;
    logic [11:0] rgb1_q;
    logic        hit1_q;

    logic        frame_start;
    logic [11:0] h12, v12, x12, y12, x_end, y_end;
    logic        hit0;
    logic [CW-1:0] col_dx, col;
    logic [RW-1:0] row;

    assign frame_start = (in.vcount == 11'd0) && (in.hcount == 11'd0);

    // The _d values equal _q except on the F cycle, so the F pixel already sees the new state.
    always_comb begin
        x_l_d   = x_l_q;
        y_l_d   = y_l_q;
        mir_l_d = mir_l_q;
        vis_l_d = vis_l_q;
        tick_d  = tick_q;
        frame_d = frame_q;
        if (frame_start) begin
            x_l_d   = xpos;
            y_l_d   = ypos;
            mir_l_d = mirror;
            vis_l_d = visible;
            if (anim_en) begin
                if (tick_q == TW'(FRAME_TICKS - 1)) begin
                    tick_d  = '0;
                    frame_d = (FRAMES == 1) ? '0 : frame_q + FIW'(1);
                end else begin
                    tick_d  = tick_q + TW'(1);
                end
            end
        end
    end

    assign h12   = {1'b0, in.hcount};
    assign v12   = {1'b0, in.vcount};
    assign x12   = {1'b0, x_l_d};
    assign y12   = {1'b0, y_l_d};
    assign x_end = x12 + 12'(SPRITE_W);
    assign y_end = y12 + 12'(SPRITE_H);

    assign hit0 = vis_l_d && !in.hblnk && !in.vblnk &&
                  (h12 >= x12) && (h12 < x_end) &&
                  (v12 >= y12) && (v12 < y_end);

    // SPRITE_W-1-dx over CW bits is simply the bitwise inverse of dx.
    assign col_dx = in.hcount[CW-1:0] - x_l_d[CW-1:0];
    assign col    = mir_l_d ? ~col_dx : col_dx;
    assign row    = in.vcount[RW-1:0] - y_l_d[RW-1:0];

    generate
        if (FA > 0) begin : g_anim
            assign pixel_addr = {frame_d[FA-1:0], row, col};
        end else begin : g_still
            assign pixel_addr = {row, col};
        end
    endgenerate

    assign frame_idx = frame_q;

    always_ff @(posedge clk60MHz or negedge rst_n) begin
        if (!rst_n) begin
            x_l_q      <= '0;
            y_l_q      <= '0;
            mir_l_q    <= 1'b0;
            vis_l_q    <= 1'b0;
            tick_q     <= '0;
            frame_q    <= '0;
            vcount1_q  <= '0;
            hcount1_q  <= '0;
            vsync1_q   <= 1'b0;
            hsync1_q   <= 1'b0;
            vblnk1_q   <= 1'b0;
            hblnk1_q   <= 1'b0;
            rgb1_q     <= '0;
            hit1_q     <= 1'b0;
            out.vcount <= '0;
            out.hcount <= '0;
            out.vsync  <= 1'b0;
            out.hsync  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            x_l_q      <= x_l_d;
            y_l_q      <= y_l_d;
            mir_l_q    <= mir_l_d;
            vis_l_q    <= vis_l_d;
            tick_q     <= tick_d;
            frame_q    <= frame_d;
            vcount1_q  <= in.vcount;
            hcount1_q  <= in.hcount;
            vsync1_q   <= in.vsync;
            hsync1_q   <= in.hsync;
            vblnk1_q   <= in.vblnk;
            hblnk1_q   <= in.hblnk;
            rgb1_q     <= in.rgb;
            hit1_q     <= hit0;
            out.vcount <= vcount1_q;
            out.hcount <= hcount1_q;
            out.vsync  <= vsync1_q;
            out.hsync  <= hsync1_q;
            out.vblnk  <= vblnk1_q;
            out.hblnk  <= hblnk1_q;
            out.rgb    <= (hit1_q && (rgb_pixel != KEY_COLOR)) ? rgb_pixel : rgb1_q;
        end
    end

endmodule

// File: tb/tb_draw_sprite.sv
// Directed bench for draw_sprite: 64x64 sprite, 4 frames, 2 ticks per animation step.
module tb_draw_sprite;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [10:0] xpos, ypos;
    logic        mirror, visible, anim_en;
    logic [11:0] rgb_pixel;
    logic [13:0] pixel_addr;
    logic [1:0]  frame_idx;

    logic        ovr_en;
    logic [13:0] ovr_addr;
    logic [11:0] ovr_data;

    int checks = 0;
    int fails  = 0;

    logic [1:0] anim_exp [8];

    vga_if vin();
    vga_if vout();

    always #5 clk = ~clk;

    draw_sprite #(
        .SPRITE_W(64), .SPRITE_H(64), .FRAMES(4), .FRAME_TICKS(2), .KEY_COLOR(12'hF0F)
    ) dut (
        .clk60MHz  (clk),
        .rst_n     (rst_n),
        .xpos      (xpos),
        .ypos      (ypos),
        .mirror    (mirror),
        .visible   (visible),
        .anim_en   (anim_en),
        .rgb_pixel (rgb_pixel),
        .pixel_addr(pixel_addr),
        .frame_idx (frame_idx),
        .in        (vin),
        .out       (vout)
    );

    // ROM contents: address-coded pattern with an optional single overridden word.
    function automatic logic [11:0] rom_f(input logic [13:0] a);
        if (ovr_en && a == ovr_addr) return ovr_data;
        return a[11:0] ^ {a[13:12], 10'h000} ^ 12'h5A5;
    endfunction

    always @(posedge clk) rgb_pixel <= rom_f(pixel_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_px(input logic [10:0] h, input logic [10:0] v,
                          input logic [11:0] bg, input logic hb);
        vin.hcount = h;
        vin.vcount = v;
        vin.rgb    = bg;
        vin.hblnk  = hb;
        vin.vblnk  = 1'b0;
        vin.hsync  = h[0];
        vin.vsync  = v[0];
    endtask

    task automatic idle();
        set_px(11'd1200, 11'd700, 12'h000, 1'b1);
    endtask

    task automatic probe(input string tag, input logic [10:0] h, input logic [10:0] v,
                         input logic [11:0] bg, input logic hb, input logic [11:0] exp_rgb);
        @(negedge clk); set_px(h, v, bg, hb);
        @(negedge clk); idle();
        @(negedge clk);
        chk({tag, ".rgb"}, vout.rgb, exp_rgb);
        chk({tag, ".hcount"}, vout.hcount, h);
    endtask

    task automatic probe_addr(input string tag, input logic [10:0] h, input logic [10:0] v,
                              input logic [13:0] exp_addr);
        @(negedge clk); set_px(h, v, 12'h000, 1'b0);
        #1 chk(tag, pixel_addr, exp_addr);
        @(negedge clk); idle();
    endtask

    task automatic frame_start();
        @(negedge clk); set_px(11'd0, 11'd0, 12'h000, 1'b0);
        @(negedge clk); idle();
    endtask

    initial begin
        anim_exp = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        rst_n   = 1'b0;
        xpos    = 11'd100;
        ypos    = 11'd50;
        mirror  = 1'b0;
        visible = 1'b1;
        anim_en = 1'b0;
        ovr_en  = 1'b0;
        ovr_addr = 14'h0000;
        ovr_data = 12'h000;
        idle();

        repeat (3) @(negedge clk);
        chk("reset.rgb", vout.rgb, 12'h000);
        chk("reset.hcount", vout.hcount, 11'd0);
        chk("reset.frame", frame_idx, 2'd0);
        rst_n = 1'b1;

        probe("pre_F", 11'd100, 11'd50, 12'h123, 1'b0, 12'h123);
        frame_start();

        probe("top_left", 11'd100, 11'd50, 12'h123, 1'b0, 12'h5A5);
        probe("bot_right", 11'd163, 11'd113, 12'h123, 1'b0, 12'hA5A);
        probe("left_out", 11'd99, 11'd50, 12'h123, 1'b0, 12'h123);
        probe("right_out", 11'd164, 11'd50, 12'h123, 1'b0, 12'h123);
        probe("below_out", 11'd100, 11'd114, 12'h124, 1'b0, 12'h124);
        probe("hblank", 11'd110, 11'd60, 12'h222, 1'b1, 12'h222);

        ovr_en = 1'b1; ovr_addr = 14'h028A; ovr_data = 12'hF0F;
        probe("key", 11'd110, 11'd60, 12'h321, 1'b0, 12'h321);
        ovr_data = 12'hF0E;
        probe("near_key", 11'd110, 11'd60, 12'h321, 1'b0, 12'hF0E);
        ovr_en = 1'b0;

        mirror = 1'b1;
        probe_addr("mir_unlatched", 11'd100, 11'd50, 14'h0000);
        frame_start();
        probe_addr("mir_left", 11'd100, 11'd50, 14'h003F);
        probe_addr("mir_right", 11'd163, 11'd50, 14'h0000);
        probe("mir_rgb", 11'd100, 11'd50, 12'h123, 1'b0, 12'h59A);
        mirror = 1'b0;

        xpos = 11'd1000;
        frame_start();
        probe("clip_first", 11'd1000, 11'd50, 12'h111, 1'b0, 12'h5A5);
        probe("clip_last", 11'd1023, 11'd50, 12'h111, 1'b0, 12'h5B2);
        probe("clip_col0", 11'd0, 11'd51, 12'h112, 1'b0, 12'h112);
        probe("clip_col39", 11'd39, 11'd51, 12'h113, 1'b0, 12'h113);

        xpos = 11'd100; ypos = 11'd250;
        frame_start();
        xpos = 11'd500;
        probe("move_old", 11'd100, 11'd300, 12'h0AA, 1'b0, 12'h925);
        probe("move_new_early", 11'd500, 11'd300, 12'h0AB, 1'b0, 12'h0AB);
        frame_start();
        probe("move_new", 11'd500, 11'd300, 12'h0AC, 1'b0, 12'h925);
        probe("move_old_gone", 11'd100, 11'd300, 12'h0AD, 1'b0, 12'h0AD);

        xpos = 11'd100; ypos = 11'd50; anim_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); set_px(11'd0, 11'd0, 12'h000, 1'b0);
            #1 chk($sformatf("anim_addr%0d", i), pixel_addr[13:12], anim_exp[i]);
            @(negedge clk); idle();
            chk($sformatf("anim_idx%0d", i), frame_idx, anim_exp[i]);
        end
        frame_start();
        frame_start();
        chk("anim_to1", frame_idx, 2'd1);
        anim_en = 1'b0;
        frame_start();
        chk("hold_a", frame_idx, 2'd1);
        frame_start();
        chk("hold_b", frame_idx, 2'd1);
        probe("frame1_rgb", 11'd100, 11'd50, 12'h123, 1'b0, 12'h1A5);

        visible = 1'b0;
        frame_start();
        probe("hidden_tl", 11'd100, 11'd50, 12'h456, 1'b0, 12'h456);
        probe("hidden_br", 11'd163, 11'd113, 12'h457, 1'b0, 12'h457);

        visible = 1'b1;
        frame_start();
        @(negedge clk); set_px(11'd100, 11'd50, 12'h777, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 chk("pre_reset.rgb", vout.rgb, 12'h1A5);
        #1 rst_n = 1'b0;
        #1;
        chk("async.rgb", vout.rgb, 12'h000);
        chk("async.hcount", vout.hcount, 11'd0);
        chk("async.vcount", vout.vcount, 11'd0);
        chk("async.frame", frame_idx, 2'd0);
        @(negedge clk); idle(); rst_n = 1'b1;
        probe("post_reset", 11'd100, 11'd50, 12'h777, 1'b0, 12'h777);
        frame_start();
        probe("post_reset_F", 11'd100, 11'd50, 12'h777, 1'b0, 12'h5A5);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
